// File: rtl/seq_gen.sv
// seq_gen: FRIDA ADC conversion sequencer producing init/samp/cmp/logic phase strobes
// Ports: clk, rst_b (async active-low); start/cont/abort control; cfg_*_len phase lengths, cfg_nbits;
//   seq_init/seq_samp/seq_cmp/seq_logic strobes, busy, done.
//   Macro SEQ_GEN_CAPTURE_EN adds comp_in, result, result_valid.
module seq_gen #(
  parameter int CNT_W    = 8,
  parameter int MAX_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_init_len,
  input  logic [CNT_W-1:0] cfg_samp_len,
  input  logic [CNT_W-1:0] cfg_cmp_len,
  input  logic [CNT_W-1:0] cfg_logic_len,
  input  logic [4:0]       cfg_nbits,
`ifdef SEQ_GEN_CAPTURE_EN
  input  logic                comp_in,
  output logic [MAX_BITS-1:0] result,
  output logic                result_valid,
`endif
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_cmp,
  output logic             seq_logic,
  output logic             busy,
  output logic             done
);
  localparam int NB_W = $clog2(MAX_BITS + 1);
  typedef enum logic [2:0] {IDLE, INIT, SAMP, CMP, LOGIC} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB_W-1:0] bit_q, bit_d, bit_inc, nbits_c, nbits_q;
  logic [CNT_W-1:0] init_m1_q, samp_m1_q, cmp_m1_q, logic_m1_q;
  logic last, load, done_d;
  logic init_d, samp_d, cmp_d, logic_d, busy_d;
  logic init_q, samp_q, cmp_q, logic_q, busy_q, done_q;
  function automatic logic [CNT_W-1:0] m1(input logic [CNT_W-1:0] l);
    return (l == '0) ? '0 : l - 1'b1;
  endfunction
  assign nbits_c = (cfg_nbits == 5'd0) ? NB_W'(1) :
                   (32'(cfg_nbits) > MAX_BITS) ? NB_W'(MAX_BITS) : NB_W'(cfg_nbits);
  assign last    = (cnt_q == '0);
  assign bit_inc = bit_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - 1'b1;
    bit_d   = bit_q;
    load    = 1'b0;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        IDLE:  if (start || cont) begin state_d = INIT; load = 1'b1; end
        INIT:  if (last) begin state_d = SAMP; cnt_d = samp_m1_q; end
        SAMP:  if (last) begin state_d = CMP; cnt_d = cmp_m1_q; end
        CMP:   if (last) begin state_d = LOGIC; cnt_d = logic_m1_q; end
        LOGIC: if (last) begin
          if (bit_inc == nbits_q) begin
            done_d  = 1'b1;
            bit_d   = '0;
            state_d = cont ? INIT : IDLE;
            load    = cont;
          end else begin
            bit_d   = bit_inc;
            state_d = CMP;
            cnt_d   = cmp_m1_q;
          end
        end
        default: state_d = IDLE;
      endcase
      if (load) begin
        cnt_d = m1(cfg_init_len);
        bit_d = '0;
      end
    end
  end
  always_comb begin
    init_d  = (state_d == INIT);
    samp_d  = (state_d == SAMP);
    cmp_d   = (state_d == CMP);
    logic_d = (state_d == LOGIC);
    busy_d  = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      nbits_q    <= '0;
      init_m1_q  <= '0;
      samp_m1_q  <= '0;
      cmp_m1_q   <= '0;
      logic_m1_q <= '0;
      {init_q, samp_q, cmp_q, logic_q, busy_q, done_q} <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      if (load) begin
        nbits_q    <= nbits_c;
        init_m1_q  <= m1(cfg_init_len);
        samp_m1_q  <= m1(cfg_samp_len);
        cmp_m1_q   <= m1(cfg_cmp_len);
        logic_m1_q <= m1(cfg_logic_len);
      end
      {init_q, samp_q, cmp_q, logic_q, busy_q, done_q} <= {init_d, samp_d, cmp_d, logic_d, busy_d, done_d};
    end
  end
  assign seq_init  = init_q;
  assign seq_samp  = samp_q;
  assign seq_cmp   = cmp_q;
  assign seq_logic = logic_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SEQ_GEN_CAPTURE_EN
  logic [MAX_BITS-1:0] shreg_q, shreg_d, result_q;
  logic rv_q;
  // shift happens on the final CMP cycle; cleared whenever a conversion (re)starts
  assign shreg_d = load ? '0 :
                   (!abort && state_q == CMP && last) ? {shreg_q[MAX_BITS-2:0], comp_in} : shreg_q;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      shreg_q  <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      result_q <= done_d ? shreg_q : result_q;
      rv_q     <= done_d;
    end
  end
  assign result       = result_q;
  assign result_valid = rv_q;
`endif
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed scoreboard bench for seq_gen
module tb_seq_gen;
  logic clk = 1'b0, rst_b = 1'b0, start = 1'b0, cont = 1'b0, abort = 1'b0;
  logic [7:0] cfg_init_len = '0, cfg_samp_len = '0, cfg_cmp_len = '0, cfg_logic_len = '0;
  logic [4:0] cfg_nbits = '0;
  logic seq_init, seq_samp, seq_cmp, seq_logic, busy, done;
`ifdef SEQ_GEN_CAPTURE_EN
  logic comp_in = 1'b0;
  logic [15:0] result;
  logic result_valid;
`endif
  seq_gen #(.CNT_W(8), .MAX_BITS(16)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .cont(cont), .abort(abort),
    .cfg_init_len(cfg_init_len), .cfg_samp_len(cfg_samp_len),
    .cfg_cmp_len(cfg_cmp_len), .cfg_logic_len(cfg_logic_len), .cfg_nbits(cfg_nbits),
`ifdef SEQ_GEN_CAPTURE_EN
    .comp_in(comp_in), .result(result), .result_valid(result_valid),
`endif
    .seq_init(seq_init), .seq_samp(seq_samp), .seq_cmp(seq_cmp), .seq_logic(seq_logic),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  logic [5:0] q[$];
  logic [5:0] obs, exp_v;
  logic carry_done = 1'b0;
  int n_vec = 0, n_bad = 0, cmp_cnt = 0, idx = 0;
  logic [3:0] bits = 4'b1011;
  task automatic push(input logic [5:0] v);
    q.push_back(v | {5'b0, carry_done});
    carry_done = 1'b0;
  endtask
  task automatic push_idle(input int k);
    repeat (k) push(6'b000000);
  endtask
  task automatic push_conv(input int li, input int ls, input int lc, input int ll, input int n);
    repeat (li) push(6'b100010);
    repeat (ls) push(6'b010010);
    repeat (n) begin
      repeat (lc) push(6'b001010);
      repeat (ll) push(6'b000110);
    end
    carry_done = 1'b1;
  endtask
  task automatic set_cfg(input int a, input int b, input int c, input int d, input int n);
    cfg_init_len = 8'(a); cfg_samp_len = 8'(b); cfg_cmp_len = 8'(c); cfg_logic_len = 8'(d);
    cfg_nbits = 5'(n);
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    @(negedge clk);
    exp_v = (q.size() != 0) ? q.pop_front() : 6'b000000;
    obs = {seq_init, seq_samp, seq_cmp, seq_logic, busy, done};
    cmp_cnt += int'(seq_cmp);
    n_vec++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp_v);
    end
`ifdef SEQ_GEN_CAPTURE_EN
    n_vec++;
    assert (result_valid === exp_v[0]) else begin
      n_bad++;
      $error("FAIL %s_rv t=%0t observed=%b expected=%b", tag, $time, result_valid, exp_v[0]);
    end
`endif
  endtask
  task automatic drain(input string tag);
    while (q.size() != 0) tick(tag);
  endtask
  initial begin
    #2;
    obs = {seq_init, seq_samp, seq_cmp, seq_logic, busy, done};
    n_vec++;
    assert (obs === 6'b0) else begin
      n_bad++;
      $error("FAIL reset observed=%b expected=%b", obs, 6'b0);
    end
    @(negedge clk);
    rst_b = 1'b1;
    push_idle(2);
    drain("idle");
    // single shot: init 2, samp 3, 4x(1,1), done in cycle 14 with busy low
    set_cfg(2, 3, 1, 1, 4);
    start = 1'b1;
    push_conv(2, 3, 1, 1, 4);
    push_idle(2);
    tick("single");
    start = 1'b0;
    drain("single");
    // start while busy is ignored
    set_cfg(1, 1, 1, 1, 1);
    start = 1'b1;
    push_conv(1, 1, 1, 1, 1);
    push_idle(2);
    tick("busy_start");
    tick("busy_start");
    start = 1'b0;
    drain("busy_start");
    // clamping
    set_cfg(0, 0, 0, 0, 0);
    start = 1'b1;
    push_conv(1, 1, 1, 1, 1);
    push_idle(2);
    tick("clamp0");
    start = 1'b0;
    drain("clamp0");
    cfg_nbits = 5'd20;
    start = 1'b1;
    push_conv(1, 1, 1, 1, 16);
    push_idle(2);
    cmp_cnt = 0;
    tick("clamp20");
    start = 1'b0;
    drain("clamp20");
    n_vec++;
    assert (cmp_cnt === 16) else begin
      n_bad++;
      $error("FAIL clamp20_cmp_pulses observed=%0d expected=%0d", cmp_cnt, 16);
    end
    // continuous mode with samp change mid-conversion and cont drop in the second one
    set_cfg(1, 3, 1, 1, 2);
    cont = 1'b1;
    push_conv(1, 3, 1, 1, 2);
    push_conv(1, 5, 1, 1, 2);
    push_idle(2);
    tick("cont");
    cfg_samp_len = 8'd5;
    repeat (10) tick("cont");
    cont = 1'b0;
    drain("cont");
    // abort during second CMP
    set_cfg(1, 1, 1, 1, 4);
    start = 1'b1;
    push(6'b100010); push(6'b010010); push(6'b001010); push(6'b000110); push(6'b001010);
    push_idle(3);
    tick("abort");
    start = 1'b0;
    repeat (4) tick("abort");
    abort = 1'b1;
    tick("abort");
    abort = 1'b0;
    drain("abort");
    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    push_idle(3);
    tick("start_abort");
    start = 1'b0;
    abort = 1'b0;
    drain("start_abort");
    // asynchronous reset during SAMP
    set_cfg(1, 3, 1, 1, 2);
    start = 1'b1;
    push(6'b100010); push(6'b010010);
    tick("rst_mid");
    start = 1'b0;
    tick("rst_mid");
    rst_b = 1'b0;
    #1;
    obs = {seq_init, seq_samp, seq_cmp, seq_logic, busy, done};
    n_vec++;
    assert (obs === 6'b0) else begin
      n_bad++;
      $error("FAIL async_rst observed=%b expected=%b", obs, 6'b0);
    end
    #2;
    rst_b = 1'b1;
    push_idle(2);
    drain("post_rst");
    start = 1'b1;
    push_conv(1, 3, 1, 1, 2);
    push_idle(2);
    tick("post_rst");
    start = 1'b0;
    drain("post_rst");
`ifdef SEQ_GEN_CAPTURE_EN
    set_cfg(1, 1, 1, 1, 4);
    start = 1'b1;
    push_conv(1, 1, 1, 1, 4);
    push_idle(2);
    idx = 0;
    tick("cap");
    start = 1'b0;
    while (q.size() != 0) begin
      if (seq_cmp && idx < 4) begin
        comp_in = bits[3-idx];
        idx++;
      end
      tick("cap");
    end
    n_vec++;
    assert (result === 16'h000B) else begin
      n_bad++;
      $error("FAIL cap_result observed=%h expected=%h", result, 16'h000B);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
